// File: rtl/conv_node_seq_pkg.sv
// Shared types and fixed-point helpers for the convolution node family.
package conv_node_seq_pkg;

  // Node control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } conv_state_e;

  // Working width of the rounding/saturation helper; accumulators are sign-extended into it.
  localparam int unsigned SAT_MAX_W = 128;

  // Accumulator width that holds N full products plus sign without overflow.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned n);
    return 2 * w + $clog2(n) + 1;
  endfunction

  // Round half up at 'frac' fractional bits, shift back to integer scale, clamp to a signed w-bit range.
  function automatic logic signed [SAT_MAX_W-1:0] sat_round(
    input logic signed [SAT_MAX_W-1:0] acc,
    input int unsigned                 frac,
    input int unsigned                 w
  );
    logic signed [SAT_MAX_W-1:0] r;
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    r = acc;
    if (frac != 0) begin
      r = r + (SAT_MAX_W'(1) << (frac - 1));
    end
    r  = r >>> frac;
    hi = (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
    lo = ~hi;
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_node_seq_if.sv
// Operand/result handshake bundle of the convolution node.
interface conv_node_seq_if #(
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned KERNEL_WIDTH = 3,
  parameter int unsigned CHANNELS     = 2
);
  logic                                                valid_i;
  logic                                                ready_o;
  logic [KERNEL_WIDTH-1:0][CHANNELS-1:0][WORD_WIDTH-1:0] data_i;
  logic [KERNEL_WIDTH-1:0][CHANNELS-1:0][WORD_WIDTH-1:0] kernel_i;
  logic [WORD_WIDTH-1:0]                               bias_i;
  logic                                                relu_en_i;
  logic                                                valid_o;
  logic                                                ready_i;
  logic [WORD_WIDTH-1:0]                               data_o;

  // Node side.
  modport slave (
    input  valid_i, data_i, kernel_i, bias_i, relu_en_i, ready_i,
    output ready_o, valid_o, data_o
  );

  // Producer/consumer side.
  modport master (
    output valid_i, data_i, kernel_i, bias_i, relu_en_i, ready_i,
    input  ready_o, valid_o, data_o
  );
endinterface

// File: rtl/conv_node_seq_fxp_round_sat.sv
// Combinational finish stage: bias add, round half up, rescale, saturate, optional ReLU.
module fxp_round_sat
  import conv_node_seq_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned ACC_W = 36,
  parameter int unsigned FRAC  = 0
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic signed [W-1:0]     bias_i,
  input  logic                    relu_en_i,
  output logic signed [W-1:0]     res_c_o
);

  logic signed [SAT_MAX_W-1:0] sum_c;
  logic signed [SAT_MAX_W-1:0] sat_c;

  // Bias is aligned to the product scale (2*FRAC) before the shared round/saturate.
  always_comb begin
    sum_c   = SAT_MAX_W'(acc_i) + (SAT_MAX_W'(bias_i) <<< FRAC);
    sat_c   = sat_round(sum_c, FRAC, W);
    res_c_o = W'(sat_c);
    if (relu_en_i && sat_c[SAT_MAX_W-1]) begin
      res_c_o = '0;
    end
  end

endmodule

// File: rtl/conv_node_seq.sv
// Sequential convolution node: one multiply per cycle over the window, then bias/round/saturate.
module conv_node_seq
  import conv_node_seq_pkg::*;
#(
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned KERNEL_WIDTH = 3,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned FRAC_BITS    = 0
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  conv_node_seq_if.slave   bus_if
);

  localparam int unsigned N      = KERNEL_WIDTH * CHANNELS;
  localparam int unsigned ACC_W  = acc_width(WORD_WIDTH, N);
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OPS_W  = N * WORD_WIDTH;
  localparam int unsigned PROD_W = 2 * WORD_WIDTH;

  conv_state_e                state_q;
  logic [OPS_W-1:0]           data_q;
  logic [OPS_W-1:0]           kern_q;
  logic signed [WORD_WIDTH-1:0] bias_q;
  logic                       relu_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic [IDX_W-1:0]           idx_q;
  logic                       ready_q;
  logic                       valid_q;
  logic [WORD_WIDTH-1:0]      res_q;

  logic signed [WORD_WIDTH-1:0] dw_c;
  logic signed [WORD_WIDTH-1:0] kw_c;
  logic signed [PROD_W-1:0]     prod_c;
  logic signed [WORD_WIDTH-1:0] res_c;

  // Packed [k][c] layout makes element (k*CHANNELS+c) the k-major, c-minor sequence.
  always_comb begin
    dw_c   = data_q[idx_q * WORD_WIDTH +: WORD_WIDTH];
    kw_c   = kern_q[idx_q * WORD_WIDTH +: WORD_WIDTH];
    prod_c = PROD_W'(dw_c) * PROD_W'(kw_c);
  end

  fxp_round_sat #(
    .W     (WORD_WIDTH),
    .ACC_W (ACC_W),
    .FRAC  (FRAC_BITS)
  ) u_round_sat (
    .acc_i     (acc_q),
    .bias_i    (bias_q),
    .relu_en_i (relu_q),
    .res_c_o   (res_c)
  );

  // Control FSM with operand latch, accumulator and registered handshake outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      kern_q  <= '0;
      bias_q  <= '0;
      relu_q  <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_if.valid_i && ready_q) begin
            data_q  <= bus_if.data_i;
            kern_q  <= bus_if.kernel_i;
            bias_q  <= bus_if.bias_i;
            relu_q  <= bus_if.relu_en_i;
            acc_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_q + ACC_W'(prod_c);
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(N - 1)) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          res_q   <= res_c;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (bus_if.ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_if.ready_o = ready_q;
  assign bus_if.valid_o = valid_q;
  assign bus_if.data_o  = res_q;

endmodule
